// File: rtl/sprite_pkg.sv
// sprite_pkg: constants and encodings shared by the sprite draw engine, its
// pixel counter and the movement controller that drives it.
//   SCREEN_W/SCREEN_H : visible VGA area, used as the clip limit
//   SPRITE_W/SPRITE_H : sprite patch size (powers of two)
//   COLOUR_W          : colour bits per pixel
//   state_t           : draw engine FSM encoding
//   src_t             : pixel source (background ROM or sprite ROM)
package sprite_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int SPRITE_W = 8;
  localparam int SPRITE_H = 8;
  localparam int COLOUR_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_DRAW,
    S_FLUSH,
    S_DONE,
    S_RELEASE
  } state_t;

  typedef enum logic {
    SRC_BG,
    SRC_CHAR
  } src_t;

endpackage

// File: rtl/sprite_pixel_counter.sv
// sprite_pixel_counter: nested column/row counter walking a W x H patch in
// row-major order (cx fastest).
//   clock, resetn : clock and synchronous active-low reset
//   clear         : force both counters to 0 (takes priority over enable)
//   enable        : advance one pixel
//   cx, cy        : current column / row
//   last          : high while the counter sits on (W-1, H-1)
module sprite_pixel_counter #(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 enable,
  output logic [$clog2(W)-1:0] cx,
  output logic [$clog2(H)-1:0] cy,
  output logic                 last
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic row_end;

  assign row_end = (cx == XW'(W - 1));
  assign last    = row_end && (cy == YW'(H - 1));

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      cx <= '0;
      cy <= '0;
    end else if (enable) begin
      if (row_end) begin
        cx <= '0;
        cy <= cy + YW'(1);
      end else begin
        cx <= cx + XW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine: answers the movement controller's draw handshake.
// drawBG repaints a SPRITE_W x SPRITE_H patch from the background ROM,
// drawChar paints the character from the sprite ROM, at the latched top-left
// (x0,y0). One ROM address per cycle; the plot strobe follows one cycle later
// together with the ROM data. Off-screen pixels are suppressed but still use
// their slot, so draw timing never depends on position.
// Optional build macro: TRANSPARENCY_EN -- sprite pixels of colour 0 are not
// plotted (background shows through). Default: every on-screen pixel plots.
// Ports:
//   clock, resetn            : clock, synchronous active-low reset
//   drawChar, drawBG         : requests, held until the matching done
//   xCoordinate, yCoordinate : patch top-left
//   char_addr / char_data    : sprite ROM (data one cycle after address)
//   bg_addr / bg_data        : background ROM, address y*320+x
//   vga_x/vga_y/vga_colour   : plot pixel; hold last plotted value
//   vga_plot                 : write strobe
//   doneChar, doneBG         : one-cycle completion pulses
module sprite_draw_engine
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int SPRITE_H = sprite_pkg::SPRITE_H,
  parameter int COLOUR_W = sprite_pkg::COLOUR_W,
  parameter int SCREEN_W = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H = sprite_pkg::SCREEN_H
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic                                 drawChar,
  input  logic                                 drawBG,
  input  logic [8:0]                           xCoordinate,
  input  logic [7:0]                           yCoordinate,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0] char_addr,
  input  logic [COLOUR_W-1:0]                  char_data,
  output logic [16:0]                          bg_addr,
  input  logic [COLOUR_W-1:0]                  bg_data,
  output logic [8:0]                           vga_x,
  output logic [7:0]                           vga_y,
  output logic [COLOUR_W-1:0]                  vga_colour,
  output logic                                 vga_plot,
  output logic                                 doneChar,
  output logic                                 doneBG
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);

  state_t state, state_nxt;
  src_t   src, src_nxt;

  logic [8:0]  x0;
  logic [7:0]  y0;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic        last;
  logic        cnt_clear;
  logic        cnt_en;
  logic        req_held;

  // 10/9-bit sums so a patch hanging off the screen edge cannot wrap back in
  logic [9:0]  sx;
  logic [8:0]  sy;
  logic [16:0] bx;
  logic [16:0] by;

  logic                p_valid;
  logic                p_in;
  src_t                p_src;
  logic [8:0]          p_x;
  logic [7:0]          p_y;
  logic [COLOUR_W-1:0] p_colour;
  logic                opaque;
  logic                plot;

  logic [8:0]          h_x;
  logic [7:0]          h_y;
  logic [COLOUR_W-1:0] h_colour;

  sprite_pixel_counter #(
    .W(SPRITE_W),
    .H(SPRITE_H)
  ) u_counter (
    .clock (clock),
    .resetn(resetn),
    .clear (cnt_clear),
    .enable(cnt_en),
    .cx    (cx),
    .cy    (cy),
    .last  (last)
  );

  assign req_held = (src == SRC_BG) ? drawBG : drawChar;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_IDLE;
      src   <= SRC_BG;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      S_IDLE: begin
        // erase wins over draw so the old character is cleared first
        if (drawBG) begin
          src_nxt   = SRC_BG;
          state_nxt = S_LATCH;
        end else if (drawChar) begin
          src_nxt   = SRC_CHAR;
          state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        cnt_clear = 1'b1;
        state_nxt = S_DRAW;
      end
      S_DRAW: begin
        cnt_en = 1'b1;
        if (last) state_nxt = S_FLUSH;
      end
      S_FLUSH:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_RELEASE;
      S_RELEASE: if (!req_held) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x0 <= '0;
      y0 <= '0;
    end else if (state == S_LATCH) begin
      x0 <= xCoordinate;
      y0 <= yCoordinate;
    end
  end

  assign sx = 10'(x0) + 10'(cx);
  assign sy = 9'(y0) + 9'(cy);
  assign bx = 17'(x0) + 17'(cx);
  assign by = 17'(y0) + 17'(cy);

  // sprite dimensions are powers of two, so cy*SPRITE_W+cx is a concatenation
  assign char_addr = (state == S_DRAW) ? {cy, cx} : '0;
  assign bg_addr   = (state == S_DRAW) ? (by * 17'(SCREEN_W) + bx) : '0;

  // pixel coordinates ride one stage behind the address to meet the ROM data
  always_ff @(posedge clock) begin
    if (!resetn) begin
      p_valid <= 1'b0;
      p_in    <= 1'b0;
      p_src   <= SRC_BG;
      p_x     <= '0;
      p_y     <= '0;
    end else begin
      p_valid <= (state == S_DRAW);
      p_in    <= (sx < 10'(SCREEN_W)) && (sy < 9'(SCREEN_H));
      p_src   <= src;
      p_x     <= sx[8:0];
      p_y     <= sy[7:0];
    end
  end

  assign p_colour = (p_src == SRC_BG) ? bg_data : char_data;

`ifdef TRANSPARENCY_EN
  assign opaque = !((p_src == SRC_CHAR) && (char_data == '0));
`else
  assign opaque = 1'b1;
`endif

  assign plot = p_valid && p_in && opaque;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      h_x      <= '0;
      h_y      <= '0;
      h_colour <= '0;
    end else if (plot) begin
      h_x      <= p_x;
      h_y      <= p_y;
      h_colour <= p_colour;
    end
  end

  assign vga_plot   = plot;
  assign vga_x      = plot ? p_x      : h_x;
  assign vga_y      = plot ? p_y      : h_y;
  assign vga_colour = plot ? p_colour : h_colour;

  assign doneBG   = (state == S_DONE) && (src == SRC_BG);
  assign doneChar = (state == S_DONE) && (src == SRC_CHAR);

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Responder to the movement controller's draw handshake: on drawBG it repaints a SPRITE_W x SPRITE_H background patch from the background ROM; on drawChar it paints the character sprite from the sprite ROM.
- The patch origin is the supplied top-left X/Y; pixels go out as plot strobes to the 320x240 VGA adapter, and completion returns as doneBG/doneChar.
- Sits between movement FSM, two synchronous ROMs and the VGA adapter.

Parameters:
- SPRITE_W, 8, sprite width in pixels (power of 2)
- SPRITE_H, 8, sprite height in pixels (power of 2)
- COLOUR_W, 3, colour bits per pixel
- SCREEN_W, 320, visible width; clip limit
- SCREEN_H, 240, visible height; clip limit

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- drawChar  in  1  character draw request; held high until doneChar seen
- drawBG  in  1  background erase request; held high until doneBG seen
- xCoordinate  in  9  patch top-left X
- yCoordinate  in  8  patch top-left Y
- char_addr  out  log2(SPRITE_W*SPRITE_H)  sprite ROM address
- char_data  in  COLOUR_W  sprite ROM data, valid 1 cycle after address
- bg_addr  out  17  background ROM address, y*320+x
- bg_data  in  COLOUR_W  background ROM data, valid 1 cycle after address
- vga_x  out  9  plot X
- vga_y  out  8  plot Y
- vga_colour  out  COLOUR_W  plot colour
- vga_plot  out  1  write strobe, one pixel per cycle
- doneChar  out  1  one-cycle pulse: character draw finished
- doneBG  out  1  one-cycle pulse: background draw finished

Behaviour:
- Reset (any state, including mid-draw): state IDLE, counters 0; every output 0. No partial draw resumes.
- States: IDLE, LATCH, DRAW, FLUSH, DONE, RELEASE.
- IDLE: if drawBG, select BG source and go to LATCH. Else if drawChar, select CHAR source and go to LATCH. drawBG wins if both are high (erase before draw).
- LATCH (1 cycle): register x0/y0 from the inputs and clear cx/cy. Coordinates are frozen for the whole draw.
- DRAW: each cycle issue one address for pixel (cx,cy), row-major, cx fastest.
  - char_addr = cy*SPRITE_W+cx.
  - bg_addr = (y0+cy)*320 + (x0+cx), computed at 17 bits; no truncation before the add.
  - Go to FLUSH after (SPRITE_W-1, SPRITE_H-1).
- Pipeline: ROM data returns 1 cycle later. Pixel coords and source select travel in a 1-stage register aligned with the data.
  - vga_plot/vga_x/vga_y/vga_colour are asserted in the cycle after the address.
  - FLUSH emits the final pixel.
- Clipping: a pixel with x0+cx >= SCREEN_W or y0+cy >= SCREEN_H is never plotted (vga_plot=0). Its slot is still consumed, so timing is independent of position. Coordinate sums use 10/9 bits, so wrap-around is impossible.
- DONE (1 cycle): pulse doneBG or doneChar according to source.
- RELEASE: wait until the served request is low, then return to IDLE. This prevents re-triggering on a request still held in the pulse cycle.
- Latency: request high in IDLE, LATCH next cycle; first plot 2 cycles after LATCH; done asserted SPRITE_W*SPRITE_H+2 cycles after LATCH. That is 66 for 8x8.
- Request dropped mid-draw: the draw completes and done still pulses. Request input changes during DRAW are ignored.
- vga_plot is 0 outside DRAW/FLUSH output slots; vga_x/vga_y/vga_colour hold their last value when not plotting.

Optional Feature:
- TRANSPARENCY_EN defined: CHAR-source pixels with colour 0 are skipped (vga_plot=0) so the background shows through. BG pixels are always plotted.
- Undefined: all in-screen pixels are plotted, including colour 0.
- Cycle timing is identical either way.

Decomposition:
- Shared package (sprite_pkg): SCREEN_W/SCREEN_H, sprite dimensions, COLOUR_W, the state encoding, and the SRC_BG/SRC_CHAR source enum. The movement FSM and top level reuse the same constants.
- One natural sub-module: sprite_pixel_counter. It holds the cx/cy nested counter with clear/enable inputs and a last-pixel flag.

Test Plan:
- BG at (95,221), 8x8: bg_addr sequence starts 221*320+95=70815. There are 64 plots, x 95..102 and y 221..228, with colours from the ROM model. doneBG pulses once, 66 cycles after LATCH.
- Char at (126,68), ramp ROM (data=addr mod 8): plots in row-major order with colour = index mod 8. doneChar is a single 1-cycle pulse. With TRANSPARENCY_EN, the 8 zero-colour pixels produce no plot.
- drawBG and drawChar raised together: the BG draw completes first (doneBG). The char draw then starts after drawBG drops, with no pixel interleaving.
- Clip at (316,236): exactly 16 plots (x 316..319, y 236..239). Done timing is still 66 cycles.
- Request held high 5 cycles past done: only one draw occurs. The engine stays in RELEASE until the drop.
- resetn low at pixel 30 of a BG draw: next cycle all outputs are 0 and the state is IDLE. A fresh drawChar after reset completes normally.
